sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO; successor to the fixed 4-bit async FIFO for same-domain paths.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_mem_2p.sv | 23 ++
 rtl/sync_fifo_param.sv | 128 ++++++++++++
 tb/tb_sync_fifo_param.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default geometry and pointer/count width derivation
// used by every FIFO variant in the codebase.
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_DEPTH = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // One extra pointer bit distinguishes full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem_2p #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable standard / FWFT read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter  int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter  int unsigned AF_LEVEL = 12,
  parameter  int unsigned AE_LEVEL = 4,
  parameter  int unsigned FWFT     = 0,
  localparam int unsigned ADDR_W   = clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              Wr_en,
  input  logic [WIDTH-1:0]  Data_in,
  input  logic              Rd_en,
  output logic [WIDTH-1:0]  Data_out,
  output logic              Data_valid,
  output logic              Wr_Full,
  output logic              Rd_Empty,
  output logic              Almost_Full,
  output logic              Almost_Empty,
  output logic [ADDR_W:0]   Count,
  input  logic              Clr_err,
  output logic              Overflow,
  output logic              Underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [ADDR_W:0]  count;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Acceptance uses pre-edge flags only, so simultaneous read/write at full or
  // empty resolves to exactly one accepted side.
  assign wr_acc = Wr_en && !full;
  assign rd_acc = Rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (Clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (Wr_en && full)  overflow_d  = 1'b1;
    if (Rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (Clk),
    .we    (wr_acc && !reset),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (Data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign Data_out   = rd_data;
      assign Data_valid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;
      logic             dvalid_q, dvalid_d;

      always_comb begin
        dout_d   = rd_acc ? rd_data : dout_q;
        dvalid_d = rd_acc;
      end

      always_ff @(posedge Clk) begin
        if (reset) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dout_q   <= dout_d;
          dvalid_q <= dvalid_d;
        end
      end

      assign Data_out   = dout_q;
      assign Data_valid = dvalid_q;
    end
  endgenerate

  assign Wr_Full      = full;
  assign Rd_Empty     = empty;
  assign Almost_Full  = (count >= AF_C);
  assign Almost_Empty = (count <= AE_C);
  assign Count        = count;
  assign Overflow     = overflow_q;
  assign Underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: standard-mode instance plus an FWFT instance
// sharing the same stimulus.
module tb_sync_fifo_param;

  logic       Clk = 1'b0;
  logic       reset, Wr_en, Rd_en, Clr_err;
  logic [3:0] Data_in;

  logic [3:0] s_dout, f_dout;
  logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  sync_fifo_param #(
    .WIDTH(4), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)
  ) u_std (
    .Clk(Clk), .reset(reset), .Wr_en(Wr_en), .Data_in(Data_in), .Rd_en(Rd_en),
    .Data_out(s_dout), .Data_valid(s_dv), .Wr_Full(s_full), .Rd_Empty(s_empty),
    .Almost_Full(s_af), .Almost_Empty(s_ae), .Count(s_count), .Clr_err(Clr_err),
    .Overflow(s_ovf), .Underflow(s_udf)
  );

  sync_fifo_param #(
    .WIDTH(4), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)
  ) u_fwft (
    .Clk(Clk), .reset(reset), .Wr_en(Wr_en), .Data_in(Data_in), .Rd_en(Rd_en),
    .Data_out(f_dout), .Data_valid(f_dv), .Wr_Full(f_full), .Rd_Empty(f_empty),
    .Almost_Full(f_af), .Almost_Empty(f_ae), .Count(f_count), .Clr_err(Clr_err),
    .Overflow(f_ovf), .Underflow(f_udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(s_count), 0);
    check({tag, "_empty"}, 32'(s_empty), 1);
    check({tag, "_ae"},    32'(s_ae), 1);
    check({tag, "_full"},  32'(s_full), 0);
    check({tag, "_af"},    32'(s_af), 0);
    check({tag, "_dout"},  32'(s_dout), 0);
    check({tag, "_dv"},    32'(s_dv), 0);
    check({tag, "_ovf"},   32'(s_ovf), 0);
    check({tag, "_udf"},   32'(s_udf), 0);
    check({tag, "_f_dv"},  32'(f_dv), 0);
  endtask

  initial begin
    reset = 1'b1; Wr_en = 1'b0; Rd_en = 1'b0; Clr_err = 1'b0; Data_in = '0;
    step();
    step();
    check_reset_state("rst");
    reset = 1'b0;
    step();
    check_reset_state("rst_idle");

    // 1: fill with 0..15, no reads
    for (int i = 0; i < 16; i++) begin
      Wr_en = 1'b1; Data_in = 4'(i);
      step();
      check("t1_count", 32'(s_count), 32'(i + 1));
      check("t1_af",    32'(s_af),    32'((i + 1) >= 12));
      check("t1_ae",    32'(s_ae),    32'((i + 1) <= 4));
      check("t1_full",  32'(s_full),  32'((i + 1) == 16));
    end
    check("t1_ovf", 32'(s_ovf), 0);

    // 2: write into full, then drain
    Data_in = 4'hA;
    step();
    Wr_en = 1'b0;
    check("t2_ovf",   32'(s_ovf), 1);
    check("t2_count", 32'(s_count), 16);
    Rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      check("t2_dout",  32'(s_dout), 32'(k));
      check("t2_dv",    32'(s_dv), 1);
      check("t2_count", 32'(s_count), 32'(15 - k));
    end
    Rd_en = 1'b0;
    step();
    check("t2_dv_off", 32'(s_dv), 0);
    check("t2_hold",   32'(s_dout), 15);
    check("t2_empty",  32'(s_empty), 1);

    // 3: underflow, clear, clear racing a new error
    Rd_en = 1'b1;
    step();
    Rd_en = 1'b0;
    check("t3_udf",   32'(s_udf), 1);
    check("t3_count", 32'(s_count), 0);
    check("t3_dv",    32'(s_dv), 0);
    Clr_err = 1'b1;
    step();
    check("t3_udf_clr", 32'(s_udf), 0);
    check("t3_ovf_clr", 32'(s_ovf), 0);
    Rd_en = 1'b1;
    step();
    Rd_en = 1'b0;
    check("t3_udf_race", 32'(s_udf), 1);
    step();
    Clr_err = 1'b0;
    check("t3_udf_clr2", 32'(s_udf), 0);

    // 4: steady simultaneous read/write at Count=5
    for (int i = 0; i < 5; i++) begin
      Wr_en = 1'b1; Data_in = 4'(i);
      step();
    end
    check("t4_count0", 32'(s_count), 5);
    Rd_en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      Data_in = 4'(5 + j);
      step();
      check("t4_dout",  32'(s_dout), 32'(j % 16));
      check("t4_count", 32'(s_count), 5);
    end
    Wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_tail", 32'(s_dout), 32'((40 + k) % 16));
    end
    Rd_en = 1'b0;
    step();
    check("t4_empty", 32'(s_empty), 1);

    // 6: reset mid-stream at Count=9 with a write still requested
    for (int i = 0; i < 9; i++) begin
      Wr_en = 1'b1; Data_in = 4'(i + 1);
      step();
    end
    check("t6_count9", 32'(s_count), 9);
    reset = 1'b1;
    step();
    check_reset_state("t6");
    reset = 1'b0; Wr_en = 1'b0;

    // 5: FWFT head word visible the cycle after the write
    Wr_en = 1'b1; Data_in = 4'h7;
    step();
    Wr_en = 1'b0;
    check("t5_dout",  32'(f_dout), 7);
    check("t5_dv",    32'(f_dv), 1);
    check("t5_empty", 32'(f_empty), 0);
    Rd_en = 1'b1;
    step();
    Rd_en = 1'b0;
    check("t5_empty_pop", 32'(f_empty), 1);
    check("t5_dv_pop",    32'(f_dv), 0);
    check("t5_count",     32'(f_count), 0);
    check("t5_std_dout",  32'(s_dout), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
